// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
package fetch_pkg;

  localparam int unsigned INSTR_W           = 32;
  localparam int unsigned ROM_WORDS_DEFAULT = 256;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; a short final word is
// zero-padded and flushed when the last byte arrives.
module byte_packer
  import fetch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_last_i,
  output logic               word_valid_o,
  output logic [INSTR_W-1:0] word_o
);

  logic [1:0]  idx_q;
  logic [23:0] acc_q;

  // acc_q only ever holds bytes below idx_q; everything above stays zero,
  // which provides the padding for a short final word.
  always_comb begin
    word_o                  = {8'h00, acc_q};
    word_o[8*idx_q +: 8]    = byte_i;
    word_valid_o            = byte_valid_i && ((idx_q == 2'd3) || byte_last_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (byte_valid_i) begin
      if (word_valid_o) begin
        idx_q <= '0;
        acc_q <= '0;
      end else begin
        idx_q <= idx_q + 2'd1;
        acc_q <= word_o[23:0];
      end
    end
  end

endmodule : byte_packer

// File: rtl/instr_fetch.sv
// Instruction ROM loaded from a byte stream, then serving single-cycle fetches
// until an out-of-range request halts it.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ROM_WORDS = ROM_WORDS_DEFAULT,
  parameter int unsigned IP_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [7:0]         load_byte,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_done,
  input  logic               fetch_req,
  input  logic [IP_W-1:0]    ip,
  output logic               fetch_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               fault
);

  localparam int unsigned WC_W  = $clog2(ROM_WORDS + 1);
  localparam int unsigned AW    = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int unsigned CMP_W = (IP_W > WC_W) ? IP_W : WC_W;

  fetch_state_e       state_q;
  logic [WC_W-1:0]    word_count_q;
  logic [WC_W-1:0]    word_count_inc;
  logic               fault_q;
  logic               valid_q;
  logic               hit_q;
  logic [INSTR_W-1:0] rd_q;
  logic [INSTR_W-1:0] mem [ROM_WORDS];

  logic               byte_xfer;
  logic               fetch_acc;
  logic               ip_hit;
  logic               word_valid;
  logic [INSTR_W-1:0] word;

  assign load_ready     = (state_q == LOAD) && !rst;
  assign fetch_ready    = (state_q == RUN) && !rst;
  assign load_done      = (state_q != LOAD);
  assign byte_xfer      = load_valid && load_ready;
  assign fetch_acc      = fetch_req && fetch_ready;
  assign ip_hit         = CMP_W'(ip) < CMP_W'(word_count_q);
  assign word_count_inc = word_count_q + WC_W'(1);

  assign instr_valid = valid_q;
  assign instr       = hit_q ? rd_q : '0;
  assign fault       = fault_q;

  byte_packer u_packer (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_valid_i (byte_xfer),
    .byte_i       (load_byte),
    .byte_last_i  (load_last),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Kept free of reset so the array maps onto synchronous-read RAM.
  always_ff @(posedge clk) begin
    if (word_valid) mem[AW'(word_count_q)] <= word;
    if (fetch_acc)  rd_q <= mem[AW'(ip)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      word_count_q <= '0;
      fault_q      <= 1'b0;
      valid_q      <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      valid_q <= fetch_acc;
      hit_q   <= fetch_acc && ip_hit;
      case (state_q)
        LOAD: begin
          if (word_valid) begin
            word_count_q <= word_count_inc;
            if (load_last || (word_count_inc == WC_W'(ROM_WORDS))) state_q <= RUN;
          end
        end
        RUN: begin
          if (fetch_acc && !ip_hit) begin
            fault_q <= 1'b1;
            state_q <= HALT;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: inputs change on the falling edge, outputs
// are sampled on the falling edge before new inputs are applied.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_done;
  logic        fetch_req = 1'b0;
  logic [15:0] ip = '0;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        fault;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  instr_fetch #(.ROM_WORDS(256), .IP_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .ip          (ip),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reset cycle also carries a stray byte and a fetch that must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    load_valid = 1'b1;
    load_byte  = 8'h99;
    load_last  = 1'b1;
    fetch_req  = 1'b1;
    ip         = '0;
    #1;
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    @(negedge clk);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst        = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    #1;
    check("post_rst_load_ready", 32'(load_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [15:0] a,
                       input logic [31:0] exp_instr, input logic exp_fault);
    @(negedge clk);
    check({tag, "_ready"}, 32'(fetch_ready), 32'd1);
    fetch_req = 1'b1;
    ip        = a;
    @(negedge clk);
    fetch_req = 1'b0;
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instr, exp_instr);
    check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
  endtask

  initial begin
    logic [7:0] b;

    // Two full words with load_last on the eighth byte
    do_reset();
    send_byte(8'h78, 1'b0); send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0); send_byte(8'h12, 1'b0);
    send_byte(8'hEF, 1'b0); send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0); send_byte(8'hDE, 1'b1);
    check("l8_done", 32'(load_done), 32'd1);
    check("l8_load_ready", 32'(load_ready), 32'd0);
    fetch("l8_ip0", 16'd0, 32'h1234_5678, 1'b0);
    fetch("l8_ip1", 16'd1, 32'hDEAD_BEEF, 1'b0);
    // ip == word_count faults and halts
    fetch("l8_ip2", 16'd2, 32'h0000_0000, 1'b1);
    @(negedge clk);
    check("halt_fetch_ready", 32'(fetch_ready), 32'd0);
    check("halt_valid", 32'(instr_valid), 32'd0);
    fetch_req = 1'b1;
    ip        = 16'd0;
    @(negedge clk);
    fetch_req = 1'b0;
    check("halt_req_ignored", 32'(instr_valid), 32'd0);
    check("halt_fault_held", 32'(fault), 32'd1);
    check("halt_load_ready", 32'(load_ready), 32'd0);

    // Reset mid-word discards the partial word
    do_reset();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    do_reset();
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b1);
    fetch("rl_ip0", 16'd0, 32'hDDCC_BBAA, 1'b0);
    fetch("rl_ip1", 16'd1, 32'h0000_0000, 1'b1);

    // Five bytes: short final word is zero-padded; back-to-back fetches
    do_reset();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0); send_byte(8'h05, 1'b1);
    fetch("l5_ip1", 16'd1, 32'h0000_0005, 1'b0);
    @(negedge clk);
    fetch_req = 1'b1;
    ip        = 16'd0;
    @(negedge clk);
    check("b2b_v0", 32'(instr_valid), 32'd1);
    check("b2b_i0", instr, 32'h0403_0201);
    ip = 16'd1;
    @(negedge clk);
    check("b2b_v1", 32'(instr_valid), 32'd1);
    check("b2b_i1", instr, 32'h0000_0005);
    ip = 16'd0;
    @(negedge clk);
    fetch_req = 1'b0;
    check("b2b_v2", 32'(instr_valid), 32'd1);
    check("b2b_i2", instr, 32'h0403_0201);
    @(negedge clk);
    check("b2b_idle", 32'(instr_valid), 32'd0);

    // Full image without load_last; byte i = i[7:0] ^ i[15:8]
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      if (i == 1023) check("full_not_done_early", 32'(load_done), 32'd0);
      b = 8'(i) ^ 8'(i >> 8);
      send_byte(b, 1'b0);
    end
    check("full_done", 32'(load_done), 32'd1);
    check("full_load_ready", 32'(load_ready), 32'd0);
    fetch("full_ip255", 16'd255, 32'hFCFD_FEFF, 1'b0);
    fetch("full_ip0", 16'd0, 32'h0302_0100, 1'b0);
    fetch("full_ip256", 16'd256, 32'h0000_0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instr_fetch
